lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Controller in the RF stage that expands one multi-register instruction into single-register micro-ops. Covers load-multiple (LM) and store-multiple (SM).
- Walks an 8-bit register mask, one register per cycle. Produces register index, memory address and store flag for each micro-op.
- Micro-op fields are steered into the RF_EX pipeline register.
- Stalls upstream stages (IF/ID/RF registers) until the last micro-op issues. Honours downstream hold and branch flush.

Parameters:
- MASK_W, 8, register-mask width = number of architectural registers.
- REG_W, 3, register index width (clog2 MASK_W).
- ADDR_W, 16, address/data width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  valid LM/SM instruction present in RF stage; sampled only in IDLE.
- is_store_in  in  1  1 = SM, 0 = LM.
- mask_in  in  MASK_W  register mask; bit i selects register Ri.
- base_addr_in  in  ADDR_W  start address (register A contents).
- hold  in  1  downstream stall; freezes all internal state.
- flush  in  1  branch/jump flush; aborts any sequence in progress.
- stall_upstream  out  1  hold IF/ID/RF registers; inject bubble as RF_EX Valid.
- busy  out  1  state == ISSUE.
- uop_valid  out  1  micro-op fields valid this cycle.
- uop_reg  out  REG_W  register index of the current micro-op.
- uop_addr  out  ADDR_W  memory address of the current micro-op.
- uop_is_store  out  1  latched is_store_in.
- uop_last  out  1  current micro-op is the final one.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rem_mask=0; addr_cnt=0; store_q=0.
  - All outputs 0 while reset is asserted.
- States: IDLE, ISSUE.
- IDLE:
  - stall_upstream = start & (mask_in != 0), combinational.
  - uop_valid=0.
  - On an edge with start=1, mask_in!=0, hold=0 and flush=0: latch rem_mask=mask_in, addr_cnt=base_addr_in, store_q=is_store_in; go to ISSUE.
  - start with mask_in==0: treated as NOP. No stall, no micro-op, stay in IDLE; the instruction passes through normally.
- ISSUE outputs (combinational from registers):
  - uop_valid=1.
  - uop_reg = index of lowest set bit of rem_mask (R0 first).
  - uop_addr = addr_cnt; uop_is_store = store_q.
  - uop_last = (rem_mask has exactly one bit set).
  - stall_upstream = ~uop_last.
- ISSUE edge update with hold=0:
  - Clear the lowest set bit of rem_mask.
  - addr_cnt = addr_cnt + 1, modulo 2^ADDR_W (wraps FFFF to 0000).
  - If uop_last: go to IDLE. The RF stage advances on this same edge.
- start is ignored while in ISSUE. The held instruction must not retrigger.
- Latency: first micro-op appears 1 cycle after start is accepted. N set bits give N consecutive micro-ops (absent hold). Total upstream stall = N cycles.
- hold=1: state, rem_mask and addr_cnt are frozen, so outputs repeat unchanged. stall_upstream keeps its value.
- flush=1 (synchronous): next state IDLE, rem_mask=0. Has priority over hold and start.
  - Combinationally forces stall_upstream=0 and uop_valid=0 in the flush cycle.
- Back-to-back: if a new LM/SM reaches RF on the edge that ends the previous sequence, it is accepted starting the next cycle. No idle gap beyond the bubble cycle.

Decomposition:
- Shared pipeline package holds:
  - MASK_W, REG_W, ADDR_W constants.
  - state enum {IDLE, ISSUE}.
  - micro-op struct {valid, reg, addr, is_store, last}.
- Sub-module lsb_prio_enc (MASK_W to REG_W index plus one-hot-clear output) computes both the index and the next mask. Reused by the forwarding logic.

Test Plan:
- LM, mask=0x05, base=0x0100:
  - C0: stall=1, valid=0.
  - C1: reg=0, addr=0x0100, last=0, stall=1.
  - C2: reg=2, addr=0x0101, last=1, stall=0.
  - C3: IDLE, busy=0.
- mask=0x00 with start=1 -> stall=0, uop_valid never 1, busy stays 0.
- SM, mask=0xFF, base=0xFFFE:
  - 8 micro-ops with regs 0..7 and addrs FFFE, FFFF, 0000..0005; uop_is_store=1.
  - last=1 only on reg 7.
- mask=0x90, hold=1 for 2 cycles after first micro-op -> reg=4/addr=base repeated 3 cycles. Then reg=7/addr=base+1, last=1.
- flush in 2nd ISSUE cycle of mask=0x0F -> same cycle stall=0, valid=0; next cycle IDLE, no further micro-ops.
- Asynchronous reset asserted mid-ISSUE -> outputs 0 immediately.
- Back-to-back LM 0x03 then SM 0x01 -> micro-ops R0, R1 (LM), bubble, R0 (SM, store=1).

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared constants and types for the LM/SM micro-op sequencer.
package lm_sm_sequencer_pkg;

  localparam int MASK_W = 8;
  localparam int REG_W  = 3;
  localparam int ADDR_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  reg_idx;
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic              last;
  } uop_t;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Instruction-in / micro-op-out signal bundle between RF stage control and the sequencer.
interface lm_sm_sequencer_if;
  import lm_sm_sequencer_pkg::*;

  logic              start;
  logic              is_store_in;
  logic [MASK_W-1:0] mask_in;
  logic [ADDR_W-1:0] base_addr_in;
  logic              hold;
  logic              flush;
  logic              stall_upstream;
  logic              busy;
  logic              uop_valid;
  logic [REG_W-1:0]  uop_reg;
  logic [ADDR_W-1:0] uop_addr;
  logic              uop_is_store;
  logic              uop_last;

  modport master (
    output start, is_store_in, mask_in, base_addr_in, hold, flush,
    input  stall_upstream, busy, uop_valid, uop_reg, uop_addr, uop_is_store, uop_last
  );

  modport slave (
    input  start, is_store_in, mask_in, base_addr_in, hold, flush,
    output stall_upstream, busy, uop_valid, uop_reg, uop_addr, uop_is_store, uop_last
  );

endinterface

// File: rtl/lm_sm_sequencer_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit and the mask with that bit cleared.
module lsb_prio_enc #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic [W-1:0]  cleared
);

  // mask & (mask - 1) drops exactly the lowest set bit
  assign cleared = mask & (mask - W'(1));

  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM instruction into per-register micro-ops, stalling upstream until the last issues.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  lm_sm_sequencer_if.slave bus
);

  state_t            state, state_nxt;
  logic [MASK_W-1:0] rem_mask, rem_mask_nxt, cleared;
  logic [ADDR_W-1:0] addr_cnt, addr_cnt_nxt;
  logic              store_q, store_nxt;
  logic [REG_W-1:0]  low_idx;
  logic              is_last;
  logic              stall;
  uop_t              uop;

  lsb_prio_enc #(.W(MASK_W), .IW(REG_W)) u_enc (
    .mask    (rem_mask),
    .idx     (low_idx),
    .cleared (cleared)
  );

  assign is_last = (rem_mask != '0) && (cleared == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rem_mask <= '0;
      addr_cnt <= '0;
      store_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem_mask <= rem_mask_nxt;
      addr_cnt <= addr_cnt_nxt;
      store_q  <= store_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_mask_nxt = rem_mask;
    addr_cnt_nxt = addr_cnt;
    store_nxt    = store_q;
    uop          = '0;
    stall        = 1'b0;

    case (state)
      IDLE: begin
        // an empty mask is a NOP and passes through without stalling
        stall = bus.start && (bus.mask_in != '0);
        if (stall && !bus.hold && !bus.flush) begin
          rem_mask_nxt = bus.mask_in;
          addr_cnt_nxt = bus.base_addr_in;
          store_nxt    = bus.is_store_in;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        uop.valid    = 1'b1;
        uop.reg_idx  = low_idx;
        uop.addr     = addr_cnt;
        uop.is_store = store_q;
        uop.last     = is_last;
        stall        = !is_last;
        if (!bus.hold) begin
          rem_mask_nxt = cleared;
          addr_cnt_nxt = addr_cnt + ADDR_W'(1);
          if (is_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.flush) begin
      state_nxt    = IDLE;
      rem_mask_nxt = '0;
      uop          = '0;
      stall        = 1'b0;
    end
  end

  // start may be high during reset; keep every output quiet until reset releases
  assign bus.stall_upstream = stall && reset;
  assign bus.busy           = (state == ISSUE);
  assign bus.uop_valid      = uop.valid;
  assign bus.uop_reg        = uop.reg_idx;
  assign bus.uop_addr       = uop.addr;
  assign bus.uop_is_store   = uop.is_store;
  assign bus.uop_last       = uop.last;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: vector table, hand-written corner sequences and random traffic vs a queue model.
module tb_lm_sm_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  lm_sm_sequencer_if ifc ();

  lm_sm_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
    logic        st;
    logic        last;
  } exp_uop_t;

  exp_uop_t q[$];

  typedef struct packed {
    logic        s;
    logic        st;
    logic [7:0]  m;
    logic [15:0] b;
    logic        h;
    logic        f;
    logic        ev;
    logic [2:0]  er;
    logic [15:0] ea;
    logic        es;
    logic        el;
    logic        estall;
    logic        ebusy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(input logic s, st, input logic [7:0] m, input logic [15:0] b,
                             input logic h, f, ev, input logic [2:0] er, input logic [15:0] ea,
                             input logic es, el, estall, ebusy);
    vec_t x;
    x.s = s; x.st = st; x.m = m; x.b = b; x.h = h; x.f = f;
    x.ev = ev; x.er = er; x.ea = ea; x.es = es; x.el = el; x.estall = estall; x.ebusy = ebusy;
    return x;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic s, st, input logic [7:0] m, input logic [15:0] b,
                       input logic h, f);
    @(negedge clock);
    ifc.start = s; ifc.is_store_in = st; ifc.mask_in = m;
    ifc.base_addr_in = b; ifc.hold = h; ifc.flush = f;
    #1;
  endtask

  // Expected micro-op list for one instruction: ascending register order, consecutive addresses.
  task automatic load_model(input logic [7:0] m, input logic [15:0] b, input logic st);
    int k = 0;
    int cnt = $countones(m);
    exp_uop_t u;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        u.r = 3'(i); u.a = b + 16'(k); u.st = st; u.last = (k == cnt - 1);
        q.push_back(u);
        k++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      if (ifc.flush) q.delete();
      else if (!ifc.hold) begin
        if (q.size() != 0) void'(q.pop_front());
        else if (ifc.start && ifc.mask_in != 8'h00) load_model(ifc.mask_in, ifc.base_addr_in, ifc.is_store_in);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic ev, estall;
    ev     = (q.size() != 0) && !ifc.flush;
    estall = ifc.flush ? 1'b0 :
             (q.size() == 0) ? (ifc.start && ifc.mask_in != 8'h00) : (q.size() > 1);
    chk({tag, "_valid"}, 32'(ifc.uop_valid), 32'(ev));
    chk({tag, "_stall"}, 32'(ifc.stall_upstream), 32'(estall));
    chk({tag, "_busy"}, 32'(ifc.busy), 32'(q.size() != 0));
    if (ev) begin
      chk({tag, "_reg"}, 32'(ifc.uop_reg), 32'(q[0].r));
      chk({tag, "_addr"}, 32'(ifc.uop_addr), 32'(q[0].a));
      chk({tag, "_store"}, 32'(ifc.uop_is_store), 32'(q[0].st));
      chk({tag, "_last"}, 32'(ifc.uop_last), 32'(q[0].last));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ifc.uop_valid), 32'd0);
    chk({tag, "_stall"}, 32'(ifc.stall_upstream), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_reg"}, 32'(ifc.uop_reg), 32'd0);
    chk({tag, "_addr"}, 32'(ifc.uop_addr), 32'd0);
    chk({tag, "_store"}, 32'(ifc.uop_is_store), 32'd0);
    chk({tag, "_last"}, 32'(ifc.uop_last), 32'd0);
  endtask

  initial begin
    logic [15:0] ea;
    string tag;

    //               s  st m      b         h  f  ev er  ea        es el stl busy
    tbl[0]  = v(1, 0, 8'h05, 16'h0100, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[1]  = v(0, 0, 8'h05, 16'h0100, 0, 0, 1, 0, 16'h0100, 0, 0, 1, 1);
    tbl[2]  = v(0, 0, 8'h05, 16'h0100, 0, 0, 1, 2, 16'h0101, 0, 1, 0, 1);
    tbl[3]  = v(0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[4]  = v(1, 0, 8'h00, 16'h1234, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 8'h00, 16'h1234, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[6]  = v(1, 0, 8'h90, 16'h2000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[7]  = v(0, 0, 8'h90, 16'h2000, 1, 0, 1, 4, 16'h2000, 0, 0, 1, 1);
    tbl[8]  = v(0, 0, 8'h90, 16'h2000, 1, 0, 1, 4, 16'h2000, 0, 0, 1, 1);
    tbl[9]  = v(0, 0, 8'h90, 16'h2000, 0, 0, 1, 4, 16'h2000, 0, 0, 1, 1);
    tbl[10] = v(0, 0, 8'h90, 16'h2000, 0, 0, 1, 7, 16'h2001, 0, 1, 0, 1);
    tbl[11] = v(0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[12] = v(1, 0, 8'h0F, 16'h0300, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[13] = v(0, 0, 8'h0F, 16'h0300, 0, 0, 1, 0, 16'h0300, 0, 0, 1, 1);
    tbl[14] = v(0, 0, 8'h0F, 16'h0300, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 1);
    tbl[15] = v(0, 0, 8'h0F, 16'h0300, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[16] = v(0, 0, 8'h0F, 16'h0300, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[17] = v(1, 0, 8'h03, 16'h0400, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[18] = v(1, 0, 8'h03, 16'h0400, 0, 0, 1, 0, 16'h0400, 0, 0, 1, 1);
    tbl[19] = v(1, 0, 8'h03, 16'h0400, 0, 0, 1, 1, 16'h0401, 0, 1, 0, 1);
    tbl[20] = v(1, 1, 8'h01, 16'h0500, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[21] = v(0, 1, 8'h01, 16'h0500, 0, 0, 1, 0, 16'h0500, 1, 1, 0, 1);
    tbl[22] = v(0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tbl[23] = v(1, 0, 8'h01, 16'h0700, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[24] = v(0, 0, 8'h01, 16'h0700, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);

    // Reset with a live instruction on the inputs: everything must stay at zero.
    ifc.start = 1'b1; ifc.is_store_in = 1'b1; ifc.mask_in = 8'h0F;
    ifc.base_addr_in = 16'hABCD; ifc.hold = 1'b0; ifc.flush = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    ifc.start = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].s, tbl[i].st, tbl[i].m, tbl[i].b, tbl[i].h, tbl[i].f);
      tag = $sformatf("vec%0d", i);
      chk({tag, "_valid"}, 32'(ifc.uop_valid), 32'(tbl[i].ev));
      chk({tag, "_stall"}, 32'(ifc.stall_upstream), 32'(tbl[i].estall));
      chk({tag, "_busy"}, 32'(ifc.busy), 32'(tbl[i].ebusy));
      if (tbl[i].ev) begin
        chk({tag, "_reg"}, 32'(ifc.uop_reg), 32'(tbl[i].er));
        chk({tag, "_addr"}, 32'(ifc.uop_addr), 32'(tbl[i].ea));
        chk({tag, "_store"}, 32'(ifc.uop_is_store), 32'(tbl[i].es));
        chk({tag, "_last"}, 32'(ifc.uop_last), 32'(tbl[i].el));
      end
      check_model({tag, "_m"});
      tick();
    end

    // Full mask store with address wrap across FFFF.
    drive(1, 1, 8'hFF, 16'hFFFE, 0, 0);
    chk("sm_ff_accept_stall", 32'(ifc.stall_upstream), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'hFF, 16'hFFFE, 0, 0);
      ea = 16'hFFFE + 16'(i);
      tag = $sformatf("sm_ff%0d", i);
      chk({tag, "_valid"}, 32'(ifc.uop_valid), 32'd1);
      chk({tag, "_reg"}, 32'(ifc.uop_reg), 32'(i));
      chk({tag, "_addr"}, 32'(ifc.uop_addr), 32'(ea));
      chk({tag, "_store"}, 32'(ifc.uop_is_store), 32'd1);
      chk({tag, "_last"}, 32'(ifc.uop_last), 32'(i == 7));
      chk({tag, "_stall"}, 32'(ifc.stall_upstream), 32'(i != 7));
      tick();
    end
    drive(0, 0, 8'h00, 16'h0000, 0, 0);
    chk("sm_ff_done_busy", 32'(ifc.busy), 32'd0);
    tick();

    // Asynchronous reset in the middle of a sequence.
    drive(1, 0, 8'h0F, 16'h0600, 0, 0);
    check_model("arst_c0");
    tick();
    drive(1, 0, 8'h0F, 16'h0600, 0, 0);
    check_model("arst_c1");
    tick();
    drive(1, 0, 8'h0F, 16'h0600, 0, 0);
    chk("arst_pre_valid", 32'(ifc.uop_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("arst");
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    ifc.start = 1'b0;
    drive(0, 0, 8'h00, 16'h0000, 0, 0);
    check_model("arst_after");
    tick();

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), m, 16'($urandom),
            logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0));
      check_model($sformatf("rand%0d", n));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
